// File: rtl/reg_pkg.sv
// Shared types for the register write-back path.
// Holds the data width, default depth and the write request bundle.
package reg_pkg;

    localparam int WIDTH = 64;
    localparam int DEPTH = 16;
    localparam int ADDRW = $clog2(DEPTH);

    typedef logic [ADDRW-1:0] reg_addr_t;
    typedef logic [WIDTH-1:0] reg_data_t;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter.sv
// Two-source write-back arbiter: loads normally win, and the ALU
// is promoted once it has been blocked STARVE_MAX cycles in a row.
module wb_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic alu_valid,
    input  logic ld_valid,
    output logic alu_ready,
    output logic ld_ready,
    output logic alu_fire,
    output logic ld_fire
);
    import reg_pkg::*;

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] MAXC = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;
    logic          boost;

    assign boost = (starve_cnt == MAXC);

    // Ready for each source depends only on the other source's valid.
    always_comb begin
        alu_ready = 1'b0;
        ld_ready  = 1'b0;
        if (!rst) begin
            if (boost) begin
                alu_ready = 1'b1;
                ld_ready  = !alu_valid;
            end else begin
                ld_ready  = 1'b1;
                alu_ready = !ld_valid;
            end
        end
    end

    assign alu_fire = alu_valid && alu_ready;
    assign ld_fire  = ld_valid && ld_ready;

    // Count consecutive cycles the ALU waited; saturates at the boost level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!alu_valid || alu_ready) begin
            starve_cnt <= '0;
        end else if (starve_cnt != MAXC) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Write-back stage in front of the register file write port.
// Registers one arbitrated write per cycle and bypasses the pending one.
module reg_writeback #(
    parameter  int DEPTH      = 16,
    parameter  int STARVE_MAX = 4,
    localparam int WIDTH      = reg_pkg::WIDTH,
    localparam int ADDRW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [ADDRW-1:0] alu_addr,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [ADDRW-1:0] ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic             wr_en,
    output logic [ADDRW-1:0] wr_addr,
    output logic [WIDTH-1:0] wr_data,
    input  logic [ADDRW-1:0] byp_addr0,
    input  logic [ADDRW-1:0] byp_addr1,
    output logic             byp_hit0,
    output logic             byp_hit1,
    output logic [WIDTH-1:0] byp_data0,
    output logic [WIDTH-1:0] byp_data1
);
    import reg_pkg::*;

    logic             alu_fire;
    logic             ld_fire;
    logic             fire;
    logic [ADDRW-1:0] sel_addr;
    reg_data_t        sel_data;

    wb_arbiter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .ld_valid  (ld_valid),
        .alu_ready (alu_ready),
        .ld_ready  (ld_ready),
        .alu_fire  (alu_fire),
        .ld_fire   (ld_fire)
    );

    assign fire = alu_fire || ld_fire;

    // Steer the winning source onto the write path.
    always_comb begin
        sel_addr = alu_addr;
        sel_data = alu_data;
        if (ld_fire) begin
            sel_addr = ld_addr;
            sel_data = ld_data;
        end
    end

    // Register the accepted write; r0 is accepted but never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            if (fire && sel_addr != '0) begin
                wr_en   <= 1'b1;
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

    assign byp_hit0  = wr_en && (byp_addr0 == wr_addr) && (byp_addr0 != '0);
    assign byp_hit1  = wr_en && (byp_addr1 == wr_addr) && (byp_addr1 != '0);
    assign byp_data0 = byp_hit0 ? wr_data : '0;
    assign byp_data1 = byp_hit1 ? wr_data : '0;

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-back stage directly upstream of the 64-bit register file's single write port.
- Arbitrates write requests from the ALU and the load unit into one registered write per cycle and drives the register file's write enable, address and data.
- Exposes a two-port bypass so same-cycle readers see the value the register file has not yet committed.
- Includes a starvation counter so a continuous load stream cannot lock the ALU out.

Parameters:
- DEPTH, 16, number of registers; must match the register file.
- STARVE_MAX, 4, consecutive blocked ALU cycles before the ALU is given priority; must be >= 1.
- WIDTH, 64, localparam, data width.
- ADDRW, $clog2(DEPTH), localparam, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_valid  in  1  ALU write request valid.
- alu_ready  out  1  ALU request accepted this cycle when high together with alu_valid.
- alu_addr  in  ADDRW  ALU destination register.
- alu_data  in  WIDTH  ALU result.
- ld_valid  in  1  load write request valid.
- ld_ready  out  1  load request accepted when high together with ld_valid.
- ld_addr  in  ADDRW  load destination register.
- ld_data  in  WIDTH  load result.
- wr_en  out  1  register file write enable (to en_in).
- wr_addr  out  ADDRW  register file write address (to addr_in).
- wr_data  out  WIDTH  register file write data (to data_in).
- byp_addr0  in  ADDRW  bypass query address, port 0.
- byp_addr1  in  ADDRW  bypass query address, port 1.
- byp_hit0  out  1  port 0 address matches the pending write.
- byp_hit1  out  1  port 1 address matches the pending write.
- byp_data0  out  WIDTH  pending write data for port 0, zero when no hit.
- byp_data1  out  WIDTH  pending write data for port 1, zero when no hit.

Behaviour:
- Reset and interface: one clock, clk; reset rst is asynchronous, active-high.
  - While rst is high: wr_en=0, wr_addr=0, wr_data=0, starve_cnt=0, alu_ready=0, ld_ready=0, byp_hit*=0.
  - Reset asserted mid-transfer drops the pending write; nothing reaches the register file.
- Arbitration (combinational, rst low): boost = (starve_cnt == STARVE_MAX).
  - Normal: ld_ready=1, alu_ready=!ld_valid. Loads win.
  - Boost: alu_ready=1, ld_ready=!alu_valid. The ALU wins.
  - Ready never depends on the same source's own valid. At most one handshake per cycle.
- Write register:
  - On a handshake with addr != 0: wr_en<=1, wr_addr<=addr, wr_data<=data.
  - Otherwise wr_en<=0, and wr_addr/wr_data hold their values.
  - A write to r0 is accepted (ready/valid completes) but suppressed.
  - Latency: handshake at edge N, wr_en high in cycle N+1, register file updated at edge N+2.
- Starvation counter, updated on each edge:
  - alu_valid && !alu_ready: increment, saturating at STARVE_MAX.
  - ALU handshake: clear to 0.
  - alu_valid low: clear to 0.
  - Width: $clog2(STARVE_MAX+1).
- Bypass (combinational):
  - byp_hitK = wr_en && byp_addrK == wr_addr && byp_addrK != 0.
  - byp_dataK = byp_hitK ? wr_data : 0.
  - Both ports are independent and may hit simultaneously on the same register.
- Back-to-back writes to the same register: each is registered in order; the bypass always reflects the newest pending one.

Decomposition:
- Shared package reg_pkg:
  - WIDTH=64.
  - Default DEPTH.
  - typedef reg_addr_t (logic [ADDRW-1:0]).
  - typedef reg_data_t (logic [WIDTH-1:0]).
  - typedef wb_req_t struct {addr, data}.
- One sub-module, wb_arbiter: two-source fixed-priority arbiter with the starvation counter.
- reg_writeback instantiates wb_arbiter and contains the write register and bypass logic.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with ld_valid=1 -> wr_en, ready and bypass outputs go 0 immediately; no write after release until a new handshake.
- Single ALU write: alu_valid=1, addr=3, data=0x1234 for one cycle -> alu_ready=1; next cycle wr_en=1, wr_addr=3, wr_data=0x1234; byp_addr0=3 gives byp_hit0=1, byp_data0=0x1234.
- r0 suppression: ld_valid=1, addr=0, data=0xFF -> ld_ready=1; next cycle wr_en=0; byp_addr0=0 gives byp_hit0=0.
- Conflict: both valid for one cycle (ld addr=5/0xAA, alu addr=6/0xBB) -> load written first; the ALU write follows one cycle later after ld_valid drops.
- Starvation with STARVE_MAX=4: ld_valid and alu_valid held high for 10 cycles -> loads accepted in cycles 0-3, ALU in cycle 4, loads in 5-8, ALU in cycle 9.
- Dual bypass: pending write r7=0xDEAD, byp_addr0=byp_addr1=7 -> both hit with 0xDEAD; byp_addr1=8 -> hit1=0, data1=0.
